// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step controller for the CPU core: debounced keys, PC breakpoint,
// core clock-enable and executed-instruction counter.

module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic key_n_i,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= key_n_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Pulse in the cycle the stable level falls, so the FSM sees it one edge later.
    assign press_o = stable_q & ~stable_d;
endmodule

// state  | meaning
// HALT   | core stopped, waiting for a key
// STEP   | one instruction executes, then HALT
// RUN    | free running until run key or breakpoint
// BREAK  | stopped on breakpoint; resume skips the match once
module cpu_run_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ADDR_W          = 16,
    parameter int CNT_W           = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              key_step_n,
    input  logic              key_run_n,
    input  logic              bp_enable,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [31:0]       pc,
    output logic              cpu_en,
    output logic              halted,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  step_count
);
    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_STEP  = 2'd1,
        S_RUN   = 2'd2,
        S_BREAK = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               skip_q, skip_d;
    logic [CNT_W-1:0]   step_count_q, step_count_d;
    logic               step_pulse, run_pulse;
    logic               bp_hit;

    wire unused_pc = ^{pc[31:ADDR_W+2], pc[1:0]};

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk_i     (CLOCK_50),
        .reset_n_i (reset_n),
        .key_n_i   (key_step_n),
        .press_o   (step_pulse)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk_i     (CLOCK_50),
        .reset_n_i (reset_n),
        .key_n_i   (key_run_n),
        .press_o   (run_pulse)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q      <= S_HALT;
            skip_q       <= 1'b0;
            step_count_q <= '0;
        end else begin
            state_q      <= state_d;
            skip_q       <= skip_d;
            step_count_q <= step_count_d;
        end
    end

    always_comb begin
        bp_hit       = bp_enable & (pc[ADDR_W+1:2] == bp_addr) & ~skip_q;
        cpu_en       = (state_q == S_STEP) | ((state_q == S_RUN) & ~bp_hit);
        state_d      = state_q;
        skip_d       = skip_q;
        step_count_d = step_count_q + CNT_W'(cpu_en);
        if (cpu_en) begin
            skip_d = 1'b0;
        end
        case (state_q)
            S_HALT: begin
                if (run_pulse)       state_d = S_RUN;
                else if (step_pulse) state_d = S_STEP;
            end
            S_STEP: state_d = S_HALT;
            S_RUN: begin
                if (run_pulse)   state_d = S_HALT;
                else if (bp_hit) state_d = S_BREAK;
            end
            S_BREAK: begin
                // Resume must let the core execute the breakpoint instruction once.
                if (run_pulse) begin
                    state_d = S_RUN;
                    skip_d  = 1'b1;
                end else if (step_pulse) begin
                    state_d = S_STEP;
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    assign halted     = (state_q == S_HALT) | (state_q == S_BREAK);
    assign state      = state_q;
    assign step_count = step_count_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a short debounce and a simple PC-advancing core model.

module tb_cpu_run_ctrl;
    localparam int DEB = 4;
    localparam int AW  = 16;
    localparam int CW  = 16;

    logic          CLOCK_50   = 1'b0;
    logic          reset_n    = 1'b0;
    logic          key_step_n = 1'b1;
    logic          key_run_n  = 1'b1;
    logic          bp_enable  = 1'b0;
    logic [AW-1:0] bp_addr    = '0;
    logic [31:0]   pc;
    logic          cpu_en;
    logic          halted;
    logic [1:0]    state;
    logic [CW-1:0] step_count;

    int vectors     = 0;
    int miscompares = 0;
    int en_cnt      = 0;

    cpu_run_ctrl #(.DEBOUNCE_CYCLES(DEB), .ADDR_W(AW), .CNT_W(CW)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .key_step_n (key_step_n),
        .key_run_n  (key_run_n),
        .bp_enable  (bp_enable),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .cpu_en     (cpu_en),
        .halted     (halted),
        .state      (state),
        .step_count (step_count)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Core model: one instruction (pc += 4) per enabled cycle.
    always @(posedge CLOCK_50) begin
        if (!reset_n)    pc <= 32'h0;
        else if (cpu_en) pc <= pc + 32'd4;
    end

    always @(negedge CLOCK_50) begin
        if (cpu_en) en_cnt++;
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int maxc, input string tag);
        int n = 0;
        while (state !== s && n < maxc) begin
            tick();
            n++;
        end
        chk(tag, {30'd0, state}, {30'd0, s});
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        int base, pulses, first, pulses_rel, gaps, n, seen, sc;
        logic hit_en;

        // Reset
        repeat (2) tick();
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd1);
        chk("rst_count", {16'd0, step_count}, 32'd0);
        reset_n = 1'b1;
        tick();
        base = en_cnt;

        // Step key with bounce
        key_step_n = 1'b0; tick();
        key_step_n = 1'b1; tick();
        key_step_n = 1'b0;
        pulses = 0; first = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (cpu_en) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        key_step_n = 1'b1;
        pulses_rel = 0;
        repeat (12) begin
            tick();
            if (cpu_en) pulses_rel++;
        end
        chk("step_pulses", pulses, 32'd1);
        chk("step_latency_le6", {31'd0, (first >= 1 && first <= 6)}, 32'd1);
        chk("step_count1", {16'd0, step_count}, 32'd1);
        chk("step_back_halt", {30'd0, state}, 32'd0);
        chk("release_no_pulse", pulses_rel, 32'd0);

        // Run / stop
        key_run_n = 1'b0;
        wait_state(2'd2, 20, "run_enter");
        chk("run_cpu_en", {31'd0, cpu_en}, 32'd1);
        key_run_n = 1'b1;
        gaps = 0;
        repeat (20) begin
            tick();
            if (!cpu_en) gaps++;
        end
        chk("run_continuous", gaps, 32'd0);
        chk("run_still_run", {30'd0, state}, 32'd2);
        key_run_n = 1'b0;
        wait_state(2'd0, 20, "run_stop");
        key_run_n = 1'b1;
        repeat (10) tick();
        chk("run_count_match", {16'd0, step_count}, en_cnt - base);
        chk("run_stay_halt", {30'd0, state}, 32'd0);

        // Breakpoint at word 0x10 (pc 0x40)
        do_reset();
        bp_enable = 1'b1;
        bp_addr   = 16'h0010;
        key_run_n = 1'b0;
        seen = 0; hit_en = 1'b1; n = 0;
        while (state !== 2'd3 && n < 100) begin
            tick();
            n++;
            if (pc == 32'h40 && state == 2'd2 && seen == 0) begin
                seen   = 1;
                hit_en = cpu_en;
            end
        end
        chk("bp_seen_hit", seen, 32'd1);
        chk("bp_hit_cpu_en", {31'd0, hit_en}, 32'd0);
        chk("bp_state", {30'd0, state}, 32'd3);
        chk("bp_count16", {16'd0, step_count}, 32'd16);
        chk("bp_pc", pc, 32'h40);
        chk("bp_halted", {31'd0, halted}, 32'd1);
        key_run_n = 1'b1;
        repeat (10) tick();
        chk("bp_hold", {30'd0, state}, 32'd3);

        // Resume past the breakpoint
        key_run_n = 1'b0;
        wait_state(2'd2, 20, "bp_resume");
        chk("resume_cpu_en", {31'd0, cpu_en}, 32'd1);
        chk("resume_pc", pc, 32'h40);
        tick();
        chk("resume_pc_next", pc, 32'h44);
        chk("resume_no_rebreak", {30'd0, state}, 32'd2);
        bp_addr   = 16'h0020;
        key_run_n = 1'b1;
        wait_state(2'd3, 60, "bp_second");
        chk("bp2_pc", pc, 32'h80);
        repeat (4) tick();

        // Break then step
        sc = step_count;
        key_step_n = 1'b0;
        wait_state(2'd1, 20, "brk_step");
        chk("brk_step_en", {31'd0, cpu_en}, 32'd1);
        tick();
        chk("brk_step_halt", {30'd0, state}, 32'd0);
        chk("brk_step_pc", pc, 32'h84);
        chk("brk_step_cnt", {16'd0, step_count}, sc + 1);
        key_step_n = 1'b1;
        repeat (10) tick();

        // Both keys in the same cycle from HALT
        bp_enable  = 1'b0;
        key_step_n = 1'b0;
        key_run_n  = 1'b0;
        n = 0;
        while (state === 2'd0 && n < 20) begin
            tick();
            n++;
        end
        chk("both_keys_run", {30'd0, state}, 32'd2);
        key_step_n = 1'b1;
        key_run_n  = 1'b1;
        repeat (10) tick();
        chk("both_release_run", {30'd0, state}, 32'd2);
        key_run_n = 1'b0;
        wait_state(2'd0, 20, "both_stop");
        key_run_n = 1'b1;
        repeat (10) tick();

        // Counter wrap: break after 65535 instructions, then one step
        do_reset();
        bp_enable = 1'b1;
        bp_addr   = 16'hFFFF;
        key_run_n = 1'b0;
        wait_state(2'd2, 20, "wrap_run");
        key_run_n = 1'b1;
        wait_state(2'd3, 70000, "wrap_break");
        chk("wrap_cnt_max", {16'd0, step_count}, 32'h0000FFFF);
        chk("wrap_pc", pc, 32'h0003FFFC);
        repeat (10) tick();
        key_step_n = 1'b0;
        wait_state(2'd1, 20, "wrap_step");
        tick();
        chk("wrap_cnt_zero", {16'd0, step_count}, 32'd0);
        chk("wrap_halt", {30'd0, state}, 32'd0);
        key_step_n = 1'b1;
        repeat (10) tick();

        // Reset during RUN
        bp_enable = 1'b0;
        key_run_n = 1'b0;
        wait_state(2'd2, 20, "rrun_enter");
        chk("rrun_cpu_en", {31'd0, cpu_en}, 32'd1);
        reset_n = 1'b0;
        tick();
        chk("rrun_cpu_en_off", {31'd0, cpu_en}, 32'd0);
        chk("rrun_state", {30'd0, state}, 32'd0);
        chk("rrun_count", {16'd0, step_count}, 32'd0);
        chk("rrun_halted", {31'd0, halted}, 32'd1);
        key_run_n = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (10) tick();
        chk("rrun_after", {30'd0, state}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
